// File: rtl/alu_mult_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_mult_seq_if
// Brief    : Start/operand/result bus and shared-ALU port bundle for alu_mult_seq
// Revision : 1.0
// ============================================================================
interface alu_mult_seq_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [WIDTH-1:0] alu_y;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [3:0]       alu_f;
   logic [4:0]       alu_shamt;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport slave (
      input  start, mcand, mplier, alu_y,
      output alu_a, alu_b, alu_f, alu_shamt, busy, done, hi, lo
   );

   modport master (
      output start, mcand, mplier, alu_y,
      input  alu_a, alu_b, alu_f, alu_shamt, busy, done, hi, lo
   );
endinterface
`default_nettype wire

// File: rtl/alu_mult_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_mult_seq
// Brief    : Unsigned 32x32->64 shift-add multiplier borrowing an external ALU
// Revision : 1.0
// ============================================================================
module alu_mult_seq #(
   parameter int WIDTH = 32
) (
   input  wire logic      clk,
   input  wire logic      rst_n,
   alu_mult_seq_if.slave  bus
);
   localparam logic [3:0] c_ALU_ADD = 4'b0010;
   localparam logic [3:0] c_ALU_NOP = 4'b0000;
   localparam logic [4:0] c_CNT_LAST = 5'd31;

   generate
      if (WIDTH != 32) begin : g_bad_width
         $error("alu_mult_seq supports WIDTH=32 only");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [4:0]       r_cnt;
   logic [WIDTH-1:0] r_mc;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;

   logic [WIDTH-1:0] w_alu_a;
   logic [WIDTH-1:0] w_alu_b;
   logic [3:0]       w_alu_f;
   logic             w_busy;
   logic             w_done;
   logic             w_carry;
   logic [WIDTH-1:0] w_sum_sel;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_alu_a     = '0;
      w_alu_b     = '0;
      w_alu_f     = c_ALU_NOP;
      w_busy      = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_state_nxt = S_CALC;
            end
         end
         S_CALC: begin
            w_alu_a = r_hi;
            w_alu_b = r_mc;
            w_alu_f = c_ALU_ADD;
            w_busy  = 1'b1;
            if (r_cnt == c_CNT_LAST) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            w_busy      = 1'b1;
            w_done      = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // The ALU hides its carry, so an unsigned wrap is detected as sum < hi.
   assign w_carry   = r_lo[0] & (bus.alu_y < r_hi);
   assign w_sum_sel = r_lo[0] ? bus.alu_y : r_hi;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt <= '0;
         r_mc  <= '0;
         r_hi  <= '0;
         r_lo  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_mc  <= bus.mcand;
                  r_hi  <= '0;
                  r_lo  <= bus.mplier;
                  r_cnt <= '0;
               end
            end
            S_CALC: begin
               r_hi  <= {w_carry, w_sum_sel[WIDTH-1:1]};
               r_lo  <= {w_sum_sel[0], r_lo[WIDTH-1:1]};
               r_cnt <= r_cnt + 5'd1;
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.alu_a     = w_alu_a;
   assign bus.alu_b     = w_alu_b;
   assign bus.alu_f     = w_alu_f;
   assign bus.alu_shamt = 5'd0;
   assign bus.busy      = w_busy;
   assign bus.done      = w_done;
   assign bus.hi        = r_hi;
   assign bus.lo        = r_lo;
endmodule
`default_nettype wire

// File: tb/tb_alu_mult_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_mult_seq
// Brief    : Directed self-checking bench for alu_mult_seq with a behavioural ALU
// Revision : 1.0
// ============================================================================
module tb_alu_mult_seq;
   logic clk;
   logic rst_n;
   logic chk_en;
   int   total;
   int   bad;

   alu_mult_seq_if #(.WIDTH(32)) bus ();

   alu_mult_seq #(.WIDTH(32)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   assign bus.alu_y = (bus.alu_f == 4'b0010) ? (bus.alu_a + bus.alu_b) : 32'h0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ALU must add exactly while calculating and be all-zero otherwise.
   always @(negedge clk) begin
      if (chk_en) begin
         if (bus.busy && !bus.done)
            check("alu_calc", {bus.alu_f, bus.alu_shamt, bus.alu_a, bus.alu_b},
                  {4'b0010, 5'd0, bus.hi, u_dut.r_mc});
         else
            check("alu_idle", {bus.alu_f, bus.alu_shamt, bus.alu_a, bus.alu_b}, 73'h0);
      end
   end

   task automatic do_mult(input string tag, input logic [31:0] mc, input logic [31:0] mp,
                          input logic [63:0] exp);
      int          busy_n  = 0;
      int          done_n  = 0;
      int          done_at = -1;
      logic [63:0] prod    = '0;
      @(negedge clk);
      bus.start  = 1'b1;
      bus.mcand  = mc;
      bus.mplier = mp;
      for (int i = 1; i <= 34; i++) begin
         @(negedge clk);
         busy_n += int'(bus.busy);
         if (bus.done) begin
            done_n++;
            done_at = i;
            prod    = {bus.hi, bus.lo};
         end
         if (i == 34)
            check({tag, "_idle_hold"}, {bus.hi, bus.lo}, exp);
         bus.start  = (i <= 33);
         bus.mcand  = $urandom;
         bus.mplier = $urandom;
      end
      check({tag, "_busy_cycles"}, 64'(busy_n), 64'd33);
      check({tag, "_done_count"}, 64'(done_n), 64'd1);
      check({tag, "_done_cycle"}, 64'(done_at), 64'd33);
      check({tag, "_product"}, prod, exp);
   endtask

   initial begin
      int          d_cnt;
      int          d_pos[3];
      logic [63:0] d_prod[3];

      total      = 0;
      bad        = 0;
      chk_en     = 1'b0;
      rst_n      = 1'b0;
      bus.start  = 1'b1;
      bus.mcand  = 32'hDEADBEEF;
      bus.mplier = 32'h12345678;
      @(posedge clk);
      chk_en = 1'b1;
      repeat (2) @(negedge clk);
      check("reset_state", {62'(0), bus.busy, bus.done}, 64'h0);
      check("reset_hilo", {bus.hi, bus.lo}, 64'h0);
      bus.start = 1'b0;
      rst_n     = 1'b1;

      do_mult("m3x5", 32'd3, 32'd5, 64'h0000_0000_0000_000F);
      repeat (5) @(negedge clk);
      check("idle_hold_later", {bus.hi, bus.lo}, 64'h0000_0000_0000_000F);
      check("idle_not_busy", {63'(0), bus.busy}, 64'h0);

      do_mult("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
      do_mult("msb", 32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000);
      do_mult("zero", 32'd0, 32'h1234, 64'h0);

      // Continuous start: only operands present at the IDLE edges may be used.
      d_cnt = 0;
      @(negedge clk);
      for (int n = 0; n <= 102; n++) begin
         if (n > 0 && bus.done) begin
            if (d_cnt < 3) begin
               d_pos[d_cnt]  = n;
               d_prod[d_cnt] = {bus.hi, bus.lo};
            end
            d_cnt++;
         end
         bus.start = (n < 102);
         case (n)
            0:       begin bus.mcand = 32'd11;         bus.mplier = 32'd13;         end
            34:      begin bus.mcand = 32'hFFFF_0000;  bus.mplier = 32'h0001_0001;  end
            68:      begin bus.mcand = 32'd7;          bus.mplier = 32'd9;          end
            default: begin bus.mcand = $urandom;       bus.mplier = $urandom;       end
         endcase
         if (n < 102) @(negedge clk);
      end
      check("chain_done_count", 64'(d_cnt), 64'd3);
      if (d_cnt == 3) begin
         check("chain_pos0", 64'(d_pos[0]), 64'd33);
         check("chain_pos1", 64'(d_pos[1]), 64'd67);
         check("chain_pos2", 64'(d_pos[2]), 64'd101);
         check("chain_prod0", d_prod[0], 64'd143);
         check("chain_prod1", d_prod[1], 64'h0000_FFFF_FFFF_0000);
         check("chain_prod2", d_prod[2], 64'd63);
      end

      // Abort mid-calculation at cnt=10.
      @(negedge clk);
      bus.start  = 1'b1;
      bus.mcand  = 32'hFFFF_FFFF;
      bus.mplier = 32'hFFFF_FFFF;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (10) @(negedge clk);
      check("abort_cnt10", 64'(u_dut.r_cnt), 64'd10);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("abort_state", {62'(0), bus.busy, bus.done}, 64'h0);
      check("abort_hilo", {bus.hi, bus.lo}, 64'h0);
      d_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         d_cnt += int'(bus.done);
      end
      check("abort_no_done", 64'(d_cnt), 64'd0);

      do_mult("m7x6", 32'd7, 32'd6, 64'h0000_0000_0000_002A);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
